// File: rtl/binary_searcher_pkg.sv
// Shared types and sizing for the binary searcher controller and datapath.
package binary_searcher_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CHECK,
    S_CALC,
    S_WAIT,
    S_COMPARE,
    S_FOUND,
    S_NOTFOUND
  } state_t;

  // Signed index compare; left/right may legally reach -1 or 32.
  function automatic logic idx_gt(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    return $signed(a) > $signed(b);
  endfunction

endpackage

// File: rtl/binary_searcher_wait_counter.sv
// Loadable 3-bit down-counter that paces the RAM read latency.
module binary_searcher_wait_counter
  import binary_searcher_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/binary_searcher_controller.sv
// Control FSM for the binary-search datapath over a 32x8 sorted RAM.
module binary_searcher_controller
  import binary_searcher_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] currentItem,
  input  logic [DATA_W-1:0] target,
  input  logic [IDX_W-1:0]  left,
  input  logic [IDX_W-1:0]  right,
  output logic              init,
  output logic              calc_m,
  output logic              move_L,
  output logic              move_R,
  output logic              ready,
  output logic              done,
  output logic              found,
  output logic              not_found
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t r_state;
  state_t w_next_state;
  logic   w_cnt_load;
  logic   w_cnt_dec;
  logic   w_cnt_zero;

  binary_searcher_wait_counter u_wait_counter (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (WAIT_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero_c   (w_cnt_zero)
  );

  // Next-state, counter control and the Mealy move strobes.
  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    move_L       = 1'b0;
    move_R       = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_INIT;
      S_INIT:    w_next_state = S_CHECK;
      S_CHECK:   w_next_state = idx_gt(left, right) ? S_NOTFOUND : S_CALC;
      S_CALC: begin
        w_cnt_load   = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (w_cnt_zero) w_next_state = S_COMPARE;
        else            w_cnt_dec    = 1'b1;
      end
      S_COMPARE: begin
        if (currentItem == target) begin
          w_next_state = S_FOUND;
        end else if (currentItem < target) begin
          move_L       = 1'b1;
          w_next_state = S_CHECK;
        end else begin
          move_R       = 1'b1;
          w_next_state = S_CHECK;
        end
      end
      S_FOUND, S_NOTFOUND: if (!start) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State register; Moore outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      ready     <= 1'b1;
      init      <= 1'b0;
      calc_m    <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      not_found <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      ready     <= (w_next_state == S_IDLE);
      init      <= (w_next_state == S_INIT);
      calc_m    <= (w_next_state == S_CALC);
      done      <= (w_next_state == S_FOUND) || (w_next_state == S_NOTFOUND);
      found     <= (w_next_state == S_FOUND);
      not_found <= (w_next_state == S_NOTFOUND);
    end
  end

endmodule

// File: tb/tb_binary_searcher_controller.sv
// Directed bench: two controllers (latency 1 and 3) each beside a behavioural datapath and RAM.
module tb_binary_searcher_controller;

  logic       clk;
  logic       reset;
  logic [1:0] start_s;
  logic [7:0] tgt_in;

  logic [1:0] init_s, calc_s, mvl_s, mvr_s, ready_s, done_s, found_s, nf_s;

  logic [7:0] mem [32];
  logic [7:0] tgt_r [2];
  logic [6:0] left_r [2];
  logic [6:0] right_r [2];
  logic [4:0] m_r [2];
  logic [7:0] pipe [2][8];
  int         nl [2];
  int         nr [2];
  logic [7:0] cur0, cur1;

  int total = 0;
  int bad   = 0;

  assign cur0 = pipe[0][0];
  assign cur1 = pipe[1][2];

  binary_searcher_controller #(.MEM_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .currentItem(cur0), .target(tgt_r[0]),
    .left(left_r[0]), .right(right_r[0]), .init(init_s[0]), .calc_m(calc_s[0]),
    .move_L(mvl_s[0]), .move_R(mvr_s[0]), .ready(ready_s[0]), .done(done_s[0]),
    .found(found_s[0]), .not_found(nf_s[0])
  );

  binary_searcher_controller #(.MEM_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .currentItem(cur1), .target(tgt_r[1]),
    .left(left_r[1]), .right(right_r[1]), .init(init_s[1]), .calc_m(calc_s[1]),
    .move_L(mvl_s[1]), .move_R(mvr_s[1]), .ready(ready_s[1]), .done(done_s[1]),
    .found(found_s[1]), .not_found(nf_s[1])
  );

  always #5 clk = ~clk;

  // Behavioural datapath, RAM read pipeline and move-pulse counters.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (init_s[g]) begin
        tgt_r[g]   <= tgt_in;
        left_r[g]  <= 7'd0;
        right_r[g] <= 7'd31;
      end else if (calc_s[g]) begin
        m_r[g] <= 5'((8'(left_r[g]) + 8'(right_r[g])) >> 1);
      end else if (mvl_s[g]) begin
        left_r[g] <= 7'(m_r[g]) + 7'd1;
      end else if (mvr_s[g]) begin
        right_r[g] <= 7'(m_r[g]) - 7'd1;
      end
      if (mvl_s[g]) nl[g] <= nl[g] + 1;
      if (mvr_s[g]) nr[g] <= nr[g] + 1;
      pipe[g][0] <= mem[m_r[g]];
      for (int k = 1; k < 8; k++) pipe[g][k] <= pipe[g][k-1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise start and run until done or the cycle bound expires.
  task automatic search(input int g, input logic [7:0] t, input int bound, output int cycles);
    tgt_in     = t;
    start_s[g] = 1'b1;
    cycles     = 0;
    while (!done_s[g] && cycles < bound) begin
      tick();
      cycles++;
    end
    check("search_done_in_bound", 32'(done_s[g]), 32'd1);
  endtask

  task automatic drop(input int g);
    start_s[g] = 1'b0;
    tick();
    check("ready_after_drop", 32'(ready_s[g]), 32'd1);
  endtask

  initial begin
    int cyc;
    int l0, r0;
    clk     = 1'b0;
    reset   = 1'b0;
    start_s = 2'b00;
    tgt_in  = 8'd0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(4 * i);
    tick();
    tick();

    check("rst_ready0", 32'(ready_s[0]), 32'd1);
    check("rst_ready1", 32'(ready_s[1]), 32'd1);
    check("rst_strobes", 32'({init_s, calc_s, mvl_s, mvr_s}), 32'd0);
    check("rst_status", 32'({done_s, found_s, nf_s}), 32'd0);
    reset = 1'b1;
    tick();

    // target 60: single probe, found in cycle 6
    l0 = nl[0]; r0 = nr[0];
    tgt_in = 8'd60;
    start_s[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) check("t60_init_c1", 32'({init_s[0], ready_s[0]}), 32'b10);
      if (c == 3) check("t60_calc_c3", 32'(calc_s[0]), 32'd1);
      if (c == 5) check("t60_nofound_c5", 32'(found_s[0]), 32'd0);
      if (c == 6) check("t60_found_c6", 32'({found_s[0], done_s[0], nf_s[0]}), 32'b110);
    end
    check("t60_moves", 32'((nl[0] - l0) + (nr[0] - r0)), 32'd0);
    drop(0);

    // target 0: four move_R then found
    l0 = nl[0]; r0 = nr[0];
    search(0, 8'd0, 100, cyc);
    check("t0_cycles", 32'(cyc), 32'd22);
    check("t0_found", 32'({found_s[0], nf_s[0]}), 32'b10);
    check("t0_move_L", 32'(nl[0] - l0), 32'd0);
    check("t0_move_R", 32'(nr[0] - r0), 32'd4);
    drop(0);

    // target 124: five move_L then found at left=31
    l0 = nl[0]; r0 = nr[0];
    search(0, 8'd124, 100, cyc);
    check("t124_cycles", 32'(cyc), 32'd26);
    check("t124_found", 32'(found_s[0]), 32'd1);
    check("t124_move_L", 32'(nl[0] - l0), 32'd5);
    check("t124_left", 32'(left_r[0]), 32'd31);
    drop(0);

    // target 61: absent, ends with left=16 right=15
    search(0, 8'd61, 100, cyc);
    check("t61_cycles", 32'(cyc), 32'd23);
    check("t61_status", 32'({nf_s[0], done_s[0], found_s[0]}), 32'b110);
    check("t61_left", 32'(left_r[0]), 32'd16);
    check("t61_right", 32'(right_r[0]), 32'd15);
    drop(0);

    // target 125: left steps past the top to 32
    search(0, 8'd125, 100, cyc);
    check("t125_cycles", 32'(cyc), 32'd27);
    check("t125_nf", 32'(nf_s[0]), 32'd1);
    check("t125_left", 32'(left_r[0]), 32'd32);
    drop(0);

    // mem[0]=2, target 1: right steps below zero to -1
    mem[0] = 8'd2;
    search(0, 8'd1, 100, cyc);
    check("t1_cycles", 32'(cyc), 32'd23);
    check("t1_nf", 32'({nf_s[0], found_s[0]}), 32'b10);
    check("t1_right", 32'(right_r[0]), 32'h7F);
    check("t1_left", 32'(left_r[0]), 32'd0);
    drop(0);
    mem[0] = 8'd0;

    // async reset during S_WAIT
    tgt_in = 8'd60;
    start_s[0] = 1'b1;
    repeat (4) tick();
    check("wait_calc_low", 32'({calc_s[0], ready_s[0]}), 32'b00);
    reset = 1'b0;
    #1;
    check("arst_ready", 32'(ready_s[0]), 32'd1);
    check("arst_outs", 32'({init_s[0], calc_s[0], mvl_s[0], mvr_s[0], done_s[0], found_s[0], nf_s[0]}), 32'd0);
    start_s[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    search(0, 8'd60, 100, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd6);
    check("post_rst_found", 32'(found_s[0]), 32'd1);
    drop(0);

    // MEM_LATENCY=3: compare in cycle 7, found held while start high
    l0 = nl[1]; r0 = nr[1];
    search(1, 8'd60, 100, cyc);
    check("l3_t60_cycles", 32'(cyc), 32'd8);
    check("l3_moves", 32'((nl[1] - l0) + (nr[1] - r0)), 32'd0);
    repeat (20) tick();
    check("l3_hold", 32'({found_s[1], done_s[1], ready_s[1]}), 32'b110);
    start_s[1] = 1'b0;
    check("l3_not_ready_yet", 32'(ready_s[1]), 32'd0);
    tick();
    check("l3_ready", 32'({ready_s[1], found_s[1]}), 32'b10);

    // MEM_LATENCY=3, target 61: six cycles per probe
    search(1, 8'd61, 200, cyc);
    check("l3_t61_cycles", 32'(cyc), 32'd33);
    check("l3_t61_nf", 32'(nf_s[1]), 32'd1);
    check("l3_t61_left", 32'(left_r[1]), 32'd16);
    drop(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
